c3lib_dbnc_filter: RTL and testbench

C3LIB_DBNC_FILTER -- requirements
Module: c3lib_dbnc_filter

---
 rtl/c3lib_dbnc_filter.sv | 111 +++++++++++
 tb/tb_c3lib_dbnc_filter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/c3lib_dbnc_filter.sv
`default_nettype none
// ============================================================================
//  Module      : c3lib_dbnc_filter
//  Description : Synchronizes an asynchronous level and only lets it through
//                after it has differed from the current output for
//                max(cfg_thresh,1) consecutive clock edges. Optional bypass
//                turns the block into a plain 2-flop synchronizer + output
//                register. Registered rise/fall pulses and a busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module c3lib_dbnc_filter #(
    parameter int   CNT_WIDTH = 8,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in,
    input  logic [CNT_WIDTH-1:0] cfg_thresh,
    input  logic                 cfg_bypass,
    output logic                 out,
    output logic                 out_rise,
    output logic                 out_fall,
    output logic                 busy
);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_s1;
    logic                 r_s2;
    logic                 r_out;
    logic                 r_rise;
    logic                 r_fall;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_out_nxt;
    logic [CNT_WIDTH-1:0] w_thresh_eff;
    logic [CNT_WIDTH:0]   w_cnt_inc;

    // A zero threshold would never be reachable by cnt+1, so treat it as 1.
    assign w_thresh_eff = (cfg_thresh == '0) ? c_ONE : cfg_thresh;
    // One extra bit so cnt+1 cannot wrap even with an all-ones threshold.
    assign w_cnt_inc    = {1'b0, r_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};

    // Next-state / next-count / next-output decision from synchronized input.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        if (cfg_bypass) begin
            w_out_nxt   = r_s2;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
        end else if (r_s2 != r_out) begin
            if (w_cnt_inc >= {1'b0, w_thresh_eff}) begin
                w_out_nxt   = r_s2;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end else begin
                // cnt+1 < T <= 2^CNT_WIDTH-1 here, so the drop of the MSB is lossless.
                w_cnt_nxt   = w_cnt_inc[CNT_WIDTH-1:0];
                w_state_nxt = ST_QUAL;
            end
        end else begin
            // Candidate disappeared: abandon any partial qualification.
            w_cnt_nxt   = '0;
            w_state_nxt = ST_STABLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Synchronizer, qualification counter, output level and edge pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= RST_VAL;
            r_s2   <= RST_VAL;
            r_out  <= RST_VAL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= in;
            r_s2   <= r_s1;
            r_out  <= w_out_nxt;
            r_cnt  <= w_cnt_nxt;
            r_rise <= w_out_nxt & ~r_out;
            r_fall <= ~w_out_nxt & r_out;
        end
    end

    assign out      = r_out;
    assign out_rise = r_rise;
    assign out_fall = r_fall;
    assign busy     = (r_state == ST_QUAL);

endmodule
`default_nettype wire

// File: tb/tb_c3lib_dbnc_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_c3lib_dbnc_filter
//  Description : Randomized bench for c3lib_dbnc_filter. Two instances (8-bit
//                counter / reset level 0 and 3-bit counter / reset level 1)
//                share in, bypass and reset; each is compared every cycle
//                against a run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_c3lib_dbnc_filter;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic       cfg_bypass;
    logic [7:0] thr0;
    logic [2:0] thr1;
    logic       out0, rise0, fall0, busy0;
    logic       out1, rise1, fall1, busy1;

    int n_cmp;
    int n_err;

    // Reference model state, one entry per instance.
    logic m_s1  [2];
    logic m_s2  [2];
    logic m_out [2];
    logic m_rise[2];
    logic m_fall[2];
    int   m_run [2];   // consecutive edges on which the synchronized level differed from out
    logic c_rv  [2];

    c3lib_dbnc_filter #(.CNT_WIDTH(8), .RST_VAL(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in(in), .cfg_thresh(thr0), .cfg_bypass(cfg_bypass),
        .out(out0), .out_rise(rise0), .out_fall(fall0), .busy(busy0)
    );

    c3lib_dbnc_filter #(.CNT_WIDTH(3), .RST_VAL(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in(in), .cfg_thresh(thr1), .cfg_bypass(cfg_bypass),
        .out(out1), .out_rise(rise1), .out_fall(fall1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int   t;
            logic nout;
            t = (k == 0) ? int'(thr0) : int'(thr1);
            if (t < 1) t = 1;
            if (!rst_n) begin
                m_s1[k]   = c_rv[k];
                m_s2[k]   = c_rv[k];
                m_out[k]  = c_rv[k];
                m_run[k]  = 0;
                m_rise[k] = 1'b0;
                m_fall[k] = 1'b0;
            end else begin
                nout = m_out[k];
                if (cfg_bypass) begin
                    nout     = m_s2[k];
                    m_run[k] = 0;
                end else if (m_s2[k] != m_out[k]) begin
                    if (m_run[k] + 1 >= t) begin
                        nout     = m_s2[k];
                        m_run[k] = 0;
                    end else begin
                        m_run[k] = m_run[k] + 1;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_rise[k] = (nout == 1'b1) && (m_out[k] == 1'b0);
                m_fall[k] = (nout == 1'b0) && (m_out[k] == 1'b1);
                m_out[k]  = nout;
                m_s2[k]   = m_s1[k];
                m_s1[k]   = in;
            end
        end
    endtask

    // One clock: update model at the rising edge, compare at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("out0",  {31'd0, out0},  {31'd0, m_out[0]});
        check_eq("rise0", {31'd0, rise0}, {31'd0, m_rise[0]});
        check_eq("fall0", {31'd0, fall0}, {31'd0, m_fall[0]});
        check_eq("busy0", {31'd0, busy0}, {31'd0, (m_run[0] > 0)});
        check_eq("out1",  {31'd0, out1},  {31'd0, m_out[1]});
        check_eq("rise1", {31'd0, rise1}, {31'd0, m_rise[1]});
        check_eq("fall1", {31'd0, fall1}, {31'd0, m_fall[1]});
        check_eq("busy1", {31'd0, busy1}, {31'd0, (m_run[1] > 0)});
        check_eq("pulse_excl0", {31'd0, rise0 & fall0}, 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        c_rv[0] = 1'b0;
        c_rv[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1'b0; m_s2[k] = 1'b0; m_out[k] = 1'b0;
            m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_run[k] = 0;
        end
        rst_n      = 1'b0;
        in         = 1'b1;
        cfg_bypass = 1'b0;
        thr0       = 8'd4;
        thr1       = 3'd7;
        repeat (3) step();

        // Directed start: T=4, clean rising level, then a short 3-cycle pulse.
        rst_n = 1'b1;
        in    = 1'b0;
        repeat (6) step();
        in = 1'b1;
        repeat (12) step();
        in = 1'b0;
        repeat (12) step();
        in = 1'b1;
        repeat (3) step();
        in = 1'b0;
        repeat (10) step();

        // Random levels with occasional threshold changes and resets mid-qualification.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0)  in = ~in;
            if ($urandom_range(19) == 0) thr0 = 8'($urandom_range(10));
            if ($urandom_range(19) == 0) thr1 = 3'($urandom_range(7));
            if ($urandom_range(29) == 0) cfg_bypass = ~cfg_bypass;
            rst_n = ($urandom_range(59) != 0);
            step();
        end

        // Largest thresholds: long holds must qualify without counter wrap.
        rst_n      = 1'b1;
        cfg_bypass = 1'b0;
        thr0       = 8'hFF;
        thr1       = 3'd7;
        for (int i = 0; i < 900; i++) begin
            if (i % 300 == 0) in = ~in;
            step();
        end

        // Threshold lowered mid-qualification.
        thr0 = 8'd8;
        in   = ~in;
        repeat (7) step();
        thr0 = 8'd2;
        repeat (4) step();

        // Bypass and zero threshold with single-cycle glitches.
        thr0 = 8'd0;
        thr1 = 3'd0;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) cfg_bypass = 1'b1;
            in = 1'($urandom_range(1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
